// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared types and constants for the register write-back stage.
package reg_writeback_ctrl_pkg;
  localparam int WORD_SIZE = 19;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    REG_NONE = 2'b00,
    REG_A    = 2'b01,
    REG_B    = 2'b10,
    REG_C    = 2'b11
  } reg_sel_t;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_HELD = 1'b1
  } wb_state_t;
endpackage

// File: rtl/reg_writeback_ctrl_hold_buf.sv
// One-entry holding buffer for an ALU result that lost arbitration to a load.
module wb_hold_buf
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = reg_writeback_ctrl_pkg::WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clear,
  input  reg_sel_t             in_dest,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 valid,
  output reg_sel_t             dest,
  output logic [WORD_SIZE-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dest  <= REG_NONE;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dest  <= in_dest;
      data  <= in_data;
    end else if (clear) begin
      valid <= 1'b0;
      dest  <= REG_NONE;
      data  <= '0;
    end
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Write-back merge of ALU results and load returns into one registered write port.
// Optional decode bypass outputs are enabled by defining WB_FORWARD_EN.
module reg_writeback_ctrl #(
  parameter int WORD_SIZE = reg_writeback_ctrl_pkg::WORD_SIZE,
  parameter int CNT_W     = reg_writeback_ctrl_pkg::CNT_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ALU_VALID,
  input  logic [1:0]           ALU_DEST,
  input  logic [WORD_SIZE-1:0] ALU_DATA,
  output logic                 ALU_READY,
  input  logic                 MEM_VALID,
  input  logic [1:0]           MEM_DEST,
  input  logic [WORD_SIZE-1:0] MEM_DATA,
  output logic [WORD_SIZE-1:0] WB_DATA,
  output logic                 LOAD_A,
  output logic                 LOAD_B,
  output logic                 LOAD_C,
  output logic [CNT_W-1:0]     WB_COUNT,
`ifdef WB_FORWARD_EN
  output logic                 FWD_VALID,
  output logic [1:0]           FWD_DEST,
  output logic [WORD_SIZE-1:0] FWD_DATA,
`endif
  output logic                 DBG_STATE
);
  import reg_writeback_ctrl_pkg::*;

  // Handshake: an ALU result transfers on a cycle where ALU_VALID and ALU_READY
  // are both high; ALU_READY depends on state only. Loads are always accepted.
  wb_state_t            state, state_nxt;
  logic                 alu_acc;
  logic                 pend_valid, wr_en;
  reg_sel_t             pend_dest;
  logic [WORD_SIZE-1:0] pend_data;
  logic                 hold_load, hold_clear, hold_valid;
  reg_sel_t             hold_dest;
  logic [WORD_SIZE-1:0] hold_data;

  assign ALU_READY = (state == WB_IDLE);
  assign DBG_STATE = state;
  assign alu_acc   = ALU_VALID && ALU_READY;

  wb_hold_buf #(.WORD_SIZE(WORD_SIZE)) u_hold (
    .clk     (CLK),
    .rst     (RST),
    .load    (hold_load),
    .clear   (hold_clear),
    .in_dest (reg_sel_t'(ALU_DEST)),
    .in_data (ALU_DATA),
    .valid   (hold_valid),
    .dest    (hold_dest),
    .data    (hold_data)
  );

  always_comb begin
    state_nxt  = state;
    pend_valid = 1'b0;
    pend_dest  = REG_NONE;
    pend_data  = '0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    case (state)
      WB_IDLE: begin
        if (MEM_VALID) begin
          pend_valid = 1'b1;
          pend_dest  = reg_sel_t'(MEM_DEST);
          pend_data  = MEM_DATA;
          // A colliding ALU result with no destination has nothing to park.
          if (alu_acc && reg_sel_t'(ALU_DEST) != REG_NONE) begin
            hold_load = 1'b1;
            state_nxt = WB_HELD;
          end
        end else if (alu_acc) begin
          pend_valid = 1'b1;
          pend_dest  = reg_sel_t'(ALU_DEST);
          pend_data  = ALU_DATA;
        end
      end
      WB_HELD: begin
        if (MEM_VALID) begin
          pend_valid = 1'b1;
          pend_dest  = reg_sel_t'(MEM_DEST);
          pend_data  = MEM_DATA;
        end else begin
          pend_valid = hold_valid;
          pend_dest  = hold_dest;
          pend_data  = hold_data;
          hold_clear = 1'b1;
          state_nxt  = WB_IDLE;
        end
      end
      default: state_nxt = WB_IDLE;
    endcase
  end

  assign wr_en = pend_valid && (pend_dest != REG_NONE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= WB_IDLE;
      WB_DATA  <= '0;
      LOAD_A   <= 1'b0;
      LOAD_B   <= 1'b0;
      LOAD_C   <= 1'b0;
      WB_COUNT <= '0;
    end else begin
      state  <= state_nxt;
      LOAD_A <= wr_en && (pend_dest == REG_A);
      LOAD_B <= wr_en && (pend_dest == REG_B);
      LOAD_C <= wr_en && (pend_dest == REG_C);
      if (wr_en) begin
        WB_DATA  <= pend_data;
        WB_COUNT <= WB_COUNT + CNT_W'(1);
      end
    end
  end

`ifdef WB_FORWARD_EN
  // FWD_DATA tracks the WB_DATA value after the next edge.
  assign FWD_VALID = !RST && wr_en;
  assign FWD_DEST  = FWD_VALID ? pend_dest : 2'b00;
  assign FWD_DATA  = RST ? '0 : (wr_en ? pend_data : WB_DATA);
`endif

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl; also checks bypass outputs when WB_FORWARD_EN is set.
module tb_reg_writeback_ctrl;
  localparam int W = 19;
  localparam int C = 16;

  logic         CLK = 1'b0;
  logic         RST;
  logic         ALU_VALID;
  logic [1:0]   ALU_DEST;
  logic [W-1:0] ALU_DATA;
  logic         ALU_READY;
  logic         MEM_VALID;
  logic [1:0]   MEM_DEST;
  logic [W-1:0] MEM_DATA;
  logic [W-1:0] WB_DATA;
  logic         LOAD_A, LOAD_B, LOAD_C;
  logic [C-1:0] WB_COUNT;
  logic         DBG_STATE;
`ifdef WB_FORWARD_EN
  logic         FWD_VALID;
  logic [1:0]   FWD_DEST;
  logic [W-1:0] FWD_DATA;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  reg_writeback_ctrl #(.WORD_SIZE(W), .CNT_W(C)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ALU_VALID (ALU_VALID),
    .ALU_DEST  (ALU_DEST),
    .ALU_DATA  (ALU_DATA),
    .ALU_READY (ALU_READY),
    .MEM_VALID (MEM_VALID),
    .MEM_DEST  (MEM_DEST),
    .MEM_DATA  (MEM_DATA),
    .WB_DATA   (WB_DATA),
    .LOAD_A    (LOAD_A),
    .LOAD_B    (LOAD_B),
    .LOAD_C    (LOAD_C),
    .WB_COUNT  (WB_COUNT),
`ifdef WB_FORWARD_EN
    .FWD_VALID (FWD_VALID),
    .FWD_DEST  (FWD_DEST),
    .FWD_DATA  (FWD_DATA),
`endif
    .DBG_STATE (DBG_STATE)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Strobes packed as {C,B,A}.
  task automatic check_wb(input string tag, input logic [2:0] loads, input logic [W-1:0] data,
                          input logic [C-1:0] count, input logic ready);
    check({tag, " loads"}, {29'd0, LOAD_C, LOAD_B, LOAD_A}, {29'd0, loads});
    check({tag, " wb_data"}, 32'(WB_DATA), 32'(data));
    check({tag, " wb_count"}, 32'(WB_COUNT), 32'(count));
    check({tag, " alu_ready"}, {31'd0, ALU_READY}, {31'd0, ready});
  endtask

  task automatic set_alu(input logic v, input logic [1:0] d, input logic [W-1:0] x);
    ALU_VALID = v; ALU_DEST = d; ALU_DATA = x;
  endtask

  task automatic set_mem(input logic v, input logic [1:0] d, input logic [W-1:0] x);
    MEM_VALID = v; MEM_DEST = d; MEM_DATA = x;
  endtask

  task automatic check_fwd(input string tag, input logic v, input logic [1:0] d, input logic [W-1:0] x);
`ifdef WB_FORWARD_EN
    #1;
    check({tag, " fwd_valid"}, {31'd0, FWD_VALID}, {31'd0, v});
    check({tag, " fwd_dest"}, {30'd0, FWD_DEST}, {30'd0, d});
    check({tag, " fwd_data"}, 32'(FWD_DATA), 32'(x));
`else
    if (v && (d == 2'b11) && (x == '1)) $display("fwd %s", tag);
`endif
  endtask

  initial begin
    RST = 1'b1;
    set_alu(1'b1, 2'b10, 19'h00005);
    set_mem(1'b0, 2'b00, '0);

    // Reset with ALU_VALID held high
    tick();
    check_fwd("reset", 1'b0, 2'b00, '0);
    tick();
    check_wb("reset", 3'b000, '0, '0, 1'b1);
    RST = 1'b0;
    set_alu(1'b0, 2'b00, '0);
    #1;
    check("post-reset ready", {31'd0, ALU_READY}, 32'd1);

    // Single ALU write to B
    set_alu(1'b1, 2'b10, 19'h1ABCD);
    check_fwd("alu fwd", 1'b1, 2'b10, 19'h1ABCD);
    tick();
    set_alu(1'b0, 2'b00, '0);
    check_wb("alu t+1", 3'b010, 19'h1ABCD, 16'd1, 1'b1);
    tick();
    check_wb("alu t+2", 3'b000, 19'h1ABCD, 16'd1, 1'b1);

    // Same-destination collision: mem first, then ALU
    set_mem(1'b1, 2'b01, 19'h00011);
    set_alu(1'b1, 2'b01, 19'h00022);
    check_fwd("coll fwd mem", 1'b1, 2'b01, 19'h00011);
    tick();
    set_mem(1'b0, 2'b00, '0);
    set_alu(1'b0, 2'b00, '0);
    check_wb("coll t+1", 3'b001, 19'h00011, 16'd2, 1'b0);
    check("coll t+1 state", {31'd0, DBG_STATE}, 32'd1);
    check_fwd("coll fwd held", 1'b1, 2'b01, 19'h00022);
    tick();
    check_wb("coll t+2", 3'b001, 19'h00022, 16'd3, 1'b1);
    tick();
    check_wb("coll t+3", 3'b000, 19'h00022, 16'd3, 1'b1);

    // Starved hold; ALU_VALID stays high while not ready and must be ignored
    set_mem(1'b1, 2'b10, 19'h00100);
    set_alu(1'b1, 2'b11, 19'h00200);
    tick();
    set_mem(1'b1, 2'b01, 19'h00101);
    set_alu(1'b1, 2'b01, 19'h07777);
    check_wb("starve t+1", 3'b010, 19'h00100, 16'd4, 1'b0);
    tick();
    set_mem(1'b1, 2'b11, 19'h00102);
    check_wb("starve t+2", 3'b001, 19'h00101, 16'd5, 1'b0);
    tick();
    set_mem(1'b0, 2'b00, '0);
    set_alu(1'b0, 2'b00, '0);
    check_wb("starve t+3", 3'b100, 19'h00102, 16'd6, 1'b0);
    tick();
    check_wb("starve t+4", 3'b100, 19'h00200, 16'd7, 1'b1);
    tick();
    check_wb("starve t+5", 3'b000, 19'h00200, 16'd7, 1'b1);

    // Destination none, alone and colliding with a load
    set_alu(1'b1, 2'b00, 19'h55555);
    check_fwd("none fwd", 1'b0, 2'b00, 19'h00200);
    tick();
    check_wb("none alu", 3'b000, 19'h00200, 16'd7, 1'b1);
    set_mem(1'b1, 2'b01, 19'h00033);
    tick();
    set_mem(1'b0, 2'b00, '0);
    set_alu(1'b0, 2'b00, '0);
    check_wb("none coll", 3'b001, 19'h00033, 16'd8, 1'b1);
    tick();
    check_wb("none coll+1", 3'b000, 19'h00033, 16'd8, 1'b1);

    // Reset while an entry is held: it is discarded
    set_mem(1'b1, 2'b10, 19'h00044);
    set_alu(1'b1, 2'b11, 19'h00066);
    tick();
    set_mem(1'b0, 2'b00, '0);
    set_alu(1'b0, 2'b00, '0);
    RST = 1'b1;
    check_wb("rst coll t+1", 3'b010, 19'h00044, 16'd9, 1'b0);
    tick();
    RST = 1'b0;
    check_wb("rst coll reset", 3'b000, '0, '0, 1'b1);
    tick();
    check_wb("rst coll after", 3'b000, '0, '0, 1'b1);

    // Counter wrap: 65535 back-to-back writes, then one more
    set_alu(1'b1, 2'b01, '0);
    for (int i = 0; i < 65535; i++) begin
      ALU_DATA = W'(i);
      tick();
    end
    check_wb("wrap preload", 3'b001, 19'h0FFFE, 16'hFFFF, 1'b1);
    ALU_DATA = 19'h12345;
    check_fwd("wrap fwd", 1'b1, 2'b01, 19'h12345);
    tick();
    set_alu(1'b0, 2'b00, '0);
    check_wb("wrap", 3'b001, 19'h12345, 16'h0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_writeback_ctrl.md
Name: reg_writeback_ctrl

Overview:
- Write-back stage directly upstream of the A-C register bank of the 19-bit CPU.
- Merges ALU results and memory-load returns into a single registered write port (WB_DATA plus one-hot LOAD_A/LOAD_B/LOAD_C) feeding each register's IN_DATA/LOAD_REG.
- Arbitrates same-cycle collisions with a one-entry ALU holding buffer and back-pressures the ALU when that buffer is occupied.

Parameters:
- WORD_SIZE, 19, data width of results and registers.
- CNT_W, 16, width of the retired-write counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- ALU_VALID  input  1  ALU result present this cycle.
- ALU_DEST  input  2  destination code: 00 none, 01 A, 10 B, 11 C.
- ALU_DATA  input  WORD_SIZE  ALU result.
- ALU_READY  output  1  block can accept an ALU result this cycle.
- MEM_VALID  input  1  load data returned; always accepted, no back-pressure.
- MEM_DEST  input  2  destination code, same encoding.
- MEM_DATA  input  WORD_SIZE  load data.
- WB_DATA  output  WORD_SIZE  write data to register bank.
- LOAD_A, LOAD_B, LOAD_C  output  1 each  one-hot write strobes.
- WB_COUNT  output  CNT_W  count of register writes performed.

Behaviour:
- Reset (RST=1 at edge):
  - WB_DATA=0; LOAD_A/B/C=0; WB_COUNT=0.
  - FSM goes to IDLE; holding buffer is cleared.
  - ALU_READY=1 in the first cycle after reset.
  - Reset mid-collision discards the held entry; nothing is written.
- Handshake and latency:
  - An ALU result is accepted when ALU_VALID and ALU_READY are both high.
  - ALU_READY is combinational from state only: 1 in IDLE, 0 in HELD.
  - Write strobe and WB_DATA are registered. Latency is 1 cycle from acceptance to the LOAD_x pulse.
  - Each strobe lasts exactly one cycle.
  - At most one LOAD_x is high in any cycle.
- Destination code 00: the value is accepted but produces no strobe and no count. WB_DATA is left unchanged.
- FSM IDLE:
  - MEM_VALID only: write mem next cycle.
  - ALU accepted only: write ALU next cycle.
  - Both in the same cycle: write mem next cycle (mem is older in program order), capture the ALU entry in the hold buffer, go to HELD.
  - Same-destination collision: mem is written first, then ALU. The ALU value is final.
- FSM HELD:
  - No MEM_VALID: write the held entry next cycle, go to IDLE.
  - MEM_VALID high: write mem next cycle, stay in HELD. The held entry waits; mem always has priority.
  - ALU_VALID is ignored while in HELD because ALU_READY=0.
- WB_COUNT:
  - Increments by 1 on each cycle a LOAD_x is asserted.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Held entry with dest 00: never stored. The collision is treated as mem-only and the FSM stays in IDLE.

Optional Feature:
- Macro: WB_FORWARD_EN.
- Defined:
  - Adds outputs FWD_VALID (1), FWD_DEST (2) and FWD_DATA (WORD_SIZE).
  - These combinationally mirror the value that will be written next edge, for decode-stage bypass.
  - FWD_VALID=0 when no write is pending or the pending dest is 00.
  - All three outputs read 0 during reset.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package constants:
  - reg_sel_t, a 2-bit enum: REG_NONE, REG_A, REG_B, REG_C.
  - wb_state_t: WB_IDLE, WB_HELD.
  - WORD_SIZE constant.
- One natural sub-module, wb_hold_buf:
  - 1-entry buffer with valid bit, dest and data.
  - Load/clear controls; synchronous reset.

Test Plan:
- Reset: RST high 2 cycles with ALU_VALID=1 -> all LOAD_x=0, WB_DATA=0, WB_COUNT=0; ALU_READY=1 after release.
- Single ALU write: ALU_VALID=1, DEST=10, DATA=0x1ABCD at cycle t -> LOAD_B=1 and WB_DATA=0x1ABCD at t+1 only; WB_COUNT=1.
- Collision: MEM(01, 0x00011) and ALU(01, 0x00022) in the same cycle t:
  - t+1: LOAD_A=1, WB_DATA=0x00011, ALU_READY=0.
  - t+2: LOAD_A=1, WB_DATA=0x00022, ALU_READY=1.
- Starved hold: collision at t, then MEM_VALID on t+1 and t+2 -> mem written t+1..t+3, held ALU written t+4, ALU_READY low t+1..t+3.
- Dest none: ALU_DEST=00 -> no strobe, WB_COUNT unchanged, WB_DATA unchanged.
- Wrap: preload 65535 writes, then one more -> WB_COUNT=0; with WB_FORWARD_EN, FWD_DATA equals the next WB_DATA every cycle.
